fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_sync_mem.sv | 28 ++
 rtl/fifo_sync.sv | 132 +++++++++++++
 tb/tb_fifo_sync.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width calculation and modulo-N pointer increment.
// Used by fifo_sync and other FIFO blocks in the library.
package fifo_pkg;

   // Smallest w with 2**w >= value; clog2(0) = clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((64'd1 << width) < 64'(value)) begin
         width++;
      end
      return width;
   endfunction

   // Pointer advance for an arbitrary depth; wraps depth-1 -> 0 without
   // relying on power-of-two rollover.
   function automatic int unsigned ptr_inc(input int unsigned ptr,
                                           input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Storage array for fifo_sync: one synchronous write port, one
// combinational read port. Contents are deliberately left unreset.
module fifo_sync_mem
   import fifo_pkg::*;
#(
   parameter int p_WIDTH    = 8,
   parameter int p_CAPACITY = 99,
   localparam int unsigned AW = (clog2(p_CAPACITY) < 1) ? 1 : clog2(p_CAPACITY)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [p_WIDTH-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [p_WIDTH-1:0] rdata
);

   logic [p_WIDTH-1:0] mem [p_CAPACITY];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO of arbitrary depth with level/status flags, sticky
// overflow/underflow, and either registered or first-word-fall-through reads.
module fifo_sync
   import fifo_pkg::*;
#(
   parameter int p_WIDTH    = 8,
   parameter int p_CAPACITY = 99,
   parameter int p_FWFT     = 0,
   parameter int p_AFULL    = p_CAPACITY - 1,
   parameter int p_AEMPTY   = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic                               wrena,
   input  logic [p_WIDTH-1:0]                 wrdata,
   input  logic                               rdena,
   output logic [p_WIDTH-1:0]                 rddata,
   output logic                               rdvalid,
   output logic                               full,
   output logic                               empty,
   output logic                               afull,
   output logic                               aempty,
   output logic [clog2(p_CAPACITY+1)-1:0]     level,
   output logic                               ovf,
   output logic                               udf
);

   localparam int unsigned PW = (clog2(p_CAPACITY) < 1) ? 1 : clog2(p_CAPACITY);
   localparam int unsigned LW = clog2(p_CAPACITY + 1);

   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr_nxt;
   logic [PW-1:0]      rd_ptr_nxt;
   logic               wr_acc;
   logic               rd_acc;
   logic [p_WIDTH-1:0] head;

   // Flags are decoded from the registered level only.
   always_comb begin
      full   = (level == LW'(p_CAPACITY));
      empty  = (level == '0);
      afull  = (level >= LW'(p_AFULL));
      aempty = (level <= LW'(p_AEMPTY));
   end

   always_comb begin
      wr_acc     = wrena & ~full  & ~flush;
      rd_acc     = rdena & ~empty & ~flush;
      wr_ptr_nxt = PW'(ptr_inc(32'(wr_ptr), p_CAPACITY));
      rd_ptr_nxt = PW'(ptr_inc(32'(rd_ptr), p_CAPACITY));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr_nxt;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr_nxt;
         end
         if (wr_acc && !rd_acc) begin
            level <= level + LW'(1);
         end else if (rd_acc && !wr_acc) begin
            level <= level - LW'(1);
         end
         // A write refused for fullness flags overflow even if a read frees space this edge.
         if (wrena && full) begin
            ovf <= 1'b1;
         end
         if (rdena && empty) begin
            udf <= 1'b1;
         end
      end
   end

   fifo_sync_mem #(
      .p_WIDTH    (p_WIDTH),
      .p_CAPACITY (p_CAPACITY)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wrdata),
      .raddr (rd_ptr),
      .rdata (head)
   );

   if (p_FWFT != 0) begin : g_fwft
      // Head word is shown directly; zero while empty so reset reads as 0.
      always_comb begin
         rdvalid = ~empty;
         rddata  = empty ? '0 : head;
      end
   end else begin : g_std
      logic [p_WIDTH-1:0] data_q;
      logic               valid_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else if (flush) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
               data_q <= head;
            end
         end
      end

      always_comb begin
         rdvalid = valid_q;
         rddata  = data_q;
      end
   end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: a standard-read and a FWFT instance share
// stimulus; expectations come from vector tables and a small queue model.
module tb_fifo_sync;

   localparam int W   = 8;
   localparam int CAP = 99;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         wrena;
   logic         rdena;
   logic [W-1:0] wrdata;

   logic [W-1:0] s_rddata, f_rddata;
   logic         s_rdvalid, f_rdvalid;
   logic         s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
   logic         f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
   logic [6:0]   s_level, f_level;

   int checks   = 0;
   int failures = 0;

   fifo_sync #(
      .p_WIDTH    (W),
      .p_CAPACITY (CAP),
      .p_FWFT     (0)
   ) dut_std (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .wrena   (wrena),
      .wrdata  (wrdata),
      .rdena   (rdena),
      .rddata  (s_rddata),
      .rdvalid (s_rdvalid),
      .full    (s_full),
      .empty   (s_empty),
      .afull   (s_afull),
      .aempty  (s_aempty),
      .level   (s_level),
      .ovf     (s_ovf),
      .udf     (s_udf)
   );

   fifo_sync #(
      .p_WIDTH    (W),
      .p_CAPACITY (CAP),
      .p_FWFT     (1)
   ) dut_fwft (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .wrena   (wrena),
      .wrdata  (wrdata),
      .rdena   (rdena),
      .rddata  (f_rddata),
      .rdvalid (f_rdvalid),
      .full    (f_full),
      .empty   (f_empty),
      .afull   (f_afull),
      .aempty  (f_aempty),
      .level   (f_level),
      .ovf     (f_ovf),
      .udf     (f_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic       rd;
      logic       fl;
      logic [7:0] d;
      int         lvl;
      logic       emp;
      logic       aemp;
      logic       vld;
      logic [7:0] q;
      logic       u;
      logic [7:0] head;
   } vec_t;

   vec_t vecs [11];

   function automatic vec_t mk(input logic wr, input logic rd, input logic fl,
                               input logic [7:0] d, input int lvl, input logic emp,
                               input logic aemp, input logic vld, input logic [7:0] q,
                               input logic u, input logic [7:0] head);
      vec_t v;
      v.wr = wr; v.rd = rd; v.fl = fl; v.d = d; v.lvl = lvl; v.emp = emp;
      v.aemp = aemp; v.vld = vld; v.q = q; v.u = u; v.head = head;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wrena = 1'b0;
      rdena = 1'b0;
      flush = 1'b0;
   endtask

   task automatic reset_pulse();
      idle();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chkn({tag, "_level"},  int'(s_level), 0);
      chk1({tag, "_empty"},  s_empty,  1'b1);
      chk1({tag, "_aempty"}, s_aempty, 1'b1);
      chk1({tag, "_full"},   s_full,   1'b0);
      chk1({tag, "_afull"},  s_afull,  1'b0);
      chk1({tag, "_rdvalid"}, s_rdvalid, 1'b0);
      chkn({tag, "_rddata"}, int'(s_rddata), 0);
      chk1({tag, "_ovf"},    s_ovf,    1'b0);
      chk1({tag, "_udf"},    s_udf,    1'b0);
      chk1({tag, "_f_rdvalid"}, f_rdvalid, 1'b0);
      chkn({tag, "_f_rddata"}, int'(f_rddata), 0);
      chkn({tag, "_f_level"}, int'(f_level), 0);
   endtask

   initial begin
      logic [7:0] q [$];
      logic [7:0] exp_d;
      logic       wr_a, rd_a;
      int         wr_cnt, rd_cnt, cyc;

      rst = 1'b0;
      wrdata = '0;
      idle();
      #1;
      check_reset_outputs("por");
      step();
      rst = 1'b1;

      // Short table: mixed write/read/flush/underflow from reset.
      vecs[0]  = mk(1, 0, 0, 8'h11, 1, 0, 1, 0, 8'h00, 0, 8'h11);
      vecs[1]  = mk(1, 0, 0, 8'h22, 2, 0, 0, 0, 8'h00, 0, 8'h11);
      vecs[2]  = mk(0, 1, 0, 8'h00, 1, 0, 1, 1, 8'h11, 0, 8'h22);
      vecs[3]  = mk(1, 1, 0, 8'h33, 1, 0, 1, 1, 8'h22, 0, 8'h33);
      vecs[4]  = mk(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h22, 0, 8'h33);
      vecs[5]  = mk(0, 1, 0, 8'h00, 0, 1, 1, 1, 8'h33, 0, 8'h00);
      vecs[6]  = mk(0, 1, 0, 8'h00, 0, 1, 1, 0, 8'h33, 1, 8'h00);
      vecs[7]  = mk(1, 1, 0, 8'h44, 1, 0, 1, 0, 8'h33, 1, 8'h44);
      vecs[8]  = mk(1, 1, 1, 8'h99, 0, 1, 1, 0, 8'h33, 0, 8'h00);
      vecs[9]  = mk(1, 0, 0, 8'h55, 1, 0, 1, 0, 8'h33, 0, 8'h55);
      vecs[10] = mk(0, 1, 0, 8'h00, 0, 1, 1, 1, 8'h55, 0, 8'h00);

      for (int i = 0; i < 11; i++) begin
         wrena  = vecs[i].wr;
         rdena  = vecs[i].rd;
         flush  = vecs[i].fl;
         wrdata = vecs[i].d;
         step();
         chkn($sformatf("v%0d_level", i), int'(s_level), vecs[i].lvl);
         chk1($sformatf("v%0d_empty", i), s_empty, vecs[i].emp);
         chk1($sformatf("v%0d_aempty", i), s_aempty, vecs[i].aemp);
         chk1($sformatf("v%0d_full", i), s_full, 1'b0);
         chk1($sformatf("v%0d_rdvalid", i), s_rdvalid, vecs[i].vld);
         chkn($sformatf("v%0d_rddata", i), int'(s_rddata), int'(vecs[i].q));
         chk1($sformatf("v%0d_udf", i), s_udf, vecs[i].u);
         chk1($sformatf("v%0d_f_rdvalid", i), f_rdvalid, ~vecs[i].emp);
         if (!vecs[i].emp) begin
            chkn($sformatf("v%0d_f_head", i), int'(f_rddata), int'(vecs[i].head));
         end
      end
      idle();

      // Fill to capacity, then one overflowing write.
      reset_pulse();
      for (int i = 0; i < CAP; i++) begin
         wrena  = 1'b1;
         wrdata = 8'(i);
         step();
         chkn($sformatf("fill%0d_level", i), int'(s_level), i + 1);
         chk1($sformatf("fill%0d_afull", i), s_afull, (i + 1) >= 98);
         chk1($sformatf("fill%0d_full", i), s_full, (i + 1) == 99);
      end
      wrdata = 8'hEE;
      step();
      wrena = 1'b0;
      chkn("ovf_level", int'(s_level), 99);
      chk1("ovf_set", s_ovf, 1'b1);
      chk1("ovf_full", s_full, 1'b1);

      // Drain with single-cycle read pulses.
      for (int i = 0; i < CAP; i++) begin
         if (i < CAP - 1) begin
            chkn($sformatf("drain%0d_f_head", i), int'(f_rddata), i);
         end
         rdena = 1'b1;
         step();
         rdena = 1'b0;
         chk1($sformatf("drain%0d_rdvalid", i), s_rdvalid, 1'b1);
         chkn($sformatf("drain%0d_rddata", i), int'(s_rddata), i);
         chkn($sformatf("drain%0d_level", i), int'(s_level), CAP - 1 - i);
         chk1($sformatf("drain%0d_ovf_sticky", i), s_ovf, 1'b1);
         step();
         chk1($sformatf("drain%0d_pulse_end", i), s_rdvalid, 1'b0);
         chkn($sformatf("drain%0d_hold", i), int'(s_rddata), i);
      end
      chk1("drained_empty", s_empty, 1'b1);
      rdena = 1'b1;
      step();
      rdena = 1'b0;
      chk1("udf_set", s_udf, 1'b1);
      chkn("udf_level", int'(s_level), 0);
      chk1("udf_no_valid", s_rdvalid, 1'b0);

      // Concurrent traffic across several pointer wraps against a queue model.
      reset_pulse();
      wr_cnt = 0;
      rd_cnt = 0;
      cyc    = 0;
      while ((wr_cnt < 990 || rd_cnt < 990) && cyc < 20000) begin
         wr_a   = (wr_cnt < 990) && (q.size() < CAP) && ($urandom_range(0, 3) != 0);
         rd_a   = (q.size() > 0) && ($urandom_range(0, 2) != 0);
         wrena  = wr_a;
         rdena  = rd_a;
         wrdata = 8'(wr_cnt);
         exp_d  = '0;
         if (rd_a) begin
            exp_d = q.pop_front();
            rd_cnt++;
         end
         step();
         if (wr_a) begin
            q.push_back(8'(wr_cnt));
            wr_cnt++;
         end
         cyc++;
         chkn("conc_level", int'(s_level), q.size());
         chk1("conc_level_bound", s_level > 7'd99, 1'b0);
         chk1("conc_rdvalid", s_rdvalid, rd_a);
         if (rd_a) begin
            chkn("conc_rddata", int'(s_rddata), int'(exp_d));
         end
         if (q.size() > 0) begin
            chkn("conc_f_head", int'(f_rddata), int'(q[0]));
         end
      end
      idle();
      chk1("conc_budget", cyc < 20000, 1'b1);
      chkn("conc_writes", wr_cnt, 990);
      chkn("conc_reads", rd_cnt, 990);
      chk1("conc_ovf", s_ovf, 1'b0);
      chk1("conc_udf", s_udf, 1'b0);

      // FWFT: a write into an empty FIFO is visible without a read.
      reset_pulse();
      chk1("fwft_empty_valid", f_rdvalid, 1'b0);
      wrena  = 1'b1;
      wrdata = 8'hA5;
      step();
      wrena = 1'b0;
      chk1("fwft_valid", f_rdvalid, 1'b1);
      chkn("fwft_data", int'(f_rddata), 8'hA5);
      chk1("fwft_std_no_valid", s_rdvalid, 1'b0);

      // Flush with simultaneous write/read clears everything.
      flush = 1'b1;
      step();
      flush = 1'b0;
      rdena = 1'b1;
      step();
      rdena = 1'b0;
      chk1("pre_flush_udf", s_udf, 1'b1);
      for (int i = 0; i < 50; i++) begin
         wrena  = 1'b1;
         wrdata = 8'(i + 100);
         step();
      end
      chkn("pre_flush_level", int'(s_level), 50);
      wrena  = 1'b1;
      rdena  = 1'b1;
      flush  = 1'b1;
      wrdata = 8'h77;
      step();
      idle();
      chkn("flush_level", int'(s_level), 0);
      chk1("flush_empty", s_empty, 1'b1);
      chk1("flush_ovf", s_ovf, 1'b0);
      chk1("flush_udf", s_udf, 1'b0);
      chk1("flush_rdvalid", s_rdvalid, 1'b0);
      wrena  = 1'b1;
      wrdata = 8'h01;
      step();
      wrena = 1'b0;
      chkn("post_flush_f_head", int'(f_rddata), 8'h01);
      rdena = 1'b1;
      step();
      rdena = 1'b0;
      chk1("post_flush_rdvalid", s_rdvalid, 1'b1);
      chkn("post_flush_rddata", int'(s_rddata), 8'h01);

      // Asynchronous reset between edges with a partly filled FIFO.
      reset_pulse();
      for (int i = 0; i < 30; i++) begin
         wrena  = 1'b1;
         wrdata = 8'(i + 1);
         step();
      end
      wrena = 1'b0;
      rdena = 1'b1;
      step();
      rdena = 1'b0;
      chkn("pre_rst_level", int'(s_level), 29);
      chkn("pre_rst_rddata", int'(s_rddata), 1);
      #3;
      rst = 1'b0;
      #1;
      check_reset_outputs("async");
      step();
      chkn("held_rst_level", int'(s_level), 0);
      #3;
      rst    = 1'b1;
      wrena  = 1'b1;
      wrdata = 8'h5A;
      step();
      wrena = 1'b0;
      chkn("first_write_level", int'(s_level), 1);
      chkn("first_write_f_head", int'(f_rddata), 8'h5A);
      rdena = 1'b1;
      step();
      rdena = 1'b0;
      chkn("first_write_rddata", int'(s_rddata), 8'h5A);
      chk1("first_write_empty", s_empty, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
